// File: rtl/j1_stack_core.sv
// J1-style dual-stack CPU core with configurable widths and stack overflow/underflow detection.
// Instructions are fetched over a cyc/ack port; data goes over a Wishbone-style port or the UART window.
module j1_stack_core #(
    parameter int DATA_W       = 32,
    parameter int PC_W         = 13,
    parameter int DSTACK_DEPTH = 32,
    parameter int RSTACK_DEPTH = 32,
    parameter int CPU_NUM      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_start,
    input  logic [PC_W-1:0]   cpu_start_adr,
    output logic              cpu_end,
    output logic              cpu_fault,
    output logic              busy,
    output logic [3:0]        cpu_num,
    output logic              inst_cyc_o,
    output logic [PC_W-1:0]   inst_pc_o,
    input  logic [31:0]       inst_i,
    input  logic              inst_ack_i,
    output logic              cyc_o,
    output logic              we_o,
    output logic [DATA_W-1:0] adr_o,
    output logic [DATA_W-1:0] dat_o,
    input  logic [DATA_W-1:0] dat_i,
    input  logic              ack_i,
    output logic              cpu_uart_rd_o,
    output logic              cpu_uart_wr_o,
    output logic              cpu_uart_adr_o,
    output logic [7:0]        cpu_uart_dat_o,
    input  logic [7:0]        cpu_uart_dat_i
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_MEM   = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;
    localparam logic [2:0] S_FAULT = 3'd5;

    localparam int DPW = $clog2(DSTACK_DEPTH);
    localparam int RPW = $clog2(RSTACK_DEPTH);
    localparam int DCW = DPW + 1;
    localparam int RCW = RPW + 1;
    localparam logic [DCW-1:0] D_FULL = DCW'(DSTACK_DEPTH);
    localparam logic [RCW-1:0] R_FULL = RCW'(RSTACK_DEPTH);

    logic [2:0]        state;
    logic [PC_W-1:0]   pc, pc_inc, pc_nx, target;
    logic [31:0]       insn;
    logic [DATA_W-1:0] t, t_nx, n, r, alu_r, rwd;
    logic [DPW-1:0]    dsp, dsp_nx;
    logic [RPW-1:0]    rsp, rsp_nx;
    logic [DCW-1:0]    dcount, dcount_nx;
    logic [RCW-1:0]    rcount, rcount_nx;
    logic [DATA_W-1:0] mem_adr, mem_dat;
    logic              mem_we, mem_ld;

    logic [DATA_W-1:0] dstack [DSTACK_DEPTH];
    logic [DATA_W-1:0] rstack [RSTACK_DEPTH];

    logic       is_lit, is_jmp, is_cjmp, is_call, is_alu;
    logic [3:0] op;
    logic       r2pc, t2n, t2r, n2m;
    logic [1:0] dcode, rcode;
    logic       d_bad, r_bad, stk_fault, halt, is_ld, is_st, uart, commit, dwe, rwe;

    assign n       = dstack[dsp];
    assign r       = rstack[rsp];
    assign pc_inc  = pc + PC_W'(1);
    assign target  = insn[PC_W-1:0];

    assign is_lit  = insn[31];
    assign is_jmp  = !is_lit && insn[30:29] == 2'b00;
    assign is_cjmp = !is_lit && insn[30:29] == 2'b01;
    assign is_call = !is_lit && insn[30:29] == 2'b10;
    assign is_alu  = !is_lit && insn[30:29] == 2'b11;
    assign op      = insn[27:24];
    assign r2pc    = insn[28];
    assign t2n     = insn[7];
    assign t2r     = insn[6];
    assign n2m     = insn[5];

    // Stack deltas as 2-bit two's complement: 01 push, 11 pop one, 10 pop two.
    assign dcode = is_lit ? 2'b01 : is_cjmp ? 2'b11 : is_alu ? insn[1:0] : 2'b00;
    assign rcode = is_call ? 2'b01 : is_alu ? insn[3:2] : 2'b00;

    assign d_bad = (dcode == 2'b01 && dcount == D_FULL) ||
                   (dcode == 2'b11 && dcount == '0) ||
                   (dcode == 2'b10 && dcount < DCW'(2));
    assign r_bad = (rcode == 2'b01 && rcount == R_FULL) ||
                   (rcode == 2'b11 && rcount == '0) ||
                   (rcode == 2'b10 && rcount < RCW'(2));

    // Return with an empty return stack is the normal halt and outranks the underflow check.
    assign halt      = is_alu && r2pc && rcount == '0;
    assign stk_fault = !halt && (d_bad || r_bad);
    assign is_ld     = is_alu && op == 4'hC;
    assign is_st     = is_alu && n2m;
    assign uart      = t[DATA_W-1 -: 4] == 4'hF;
    assign commit    = state == S_EXEC && !halt && !stk_fault;

    assign dsp_nx    = dsp + DPW'($signed(dcode));
    assign rsp_nx    = rsp + RPW'($signed(rcode));
    assign dcount_nx = dcount + DCW'($signed(dcode));
    assign rcount_nx = rcount + RCW'($signed(rcode));

    always_comb begin
        alu_r = t;
        case (op)
            4'h0: alu_r = t;
            4'h1: alu_r = n;
            4'h2: alu_r = t + n;
            4'h3: alu_r = t & n;
            4'h4: alu_r = t | n;
            4'h5: alu_r = t ^ n;
            4'h6: alu_r = ~t;
            4'h7: alu_r = {DATA_W{n == t}};
            4'h8: alu_r = {DATA_W{$signed(n) < $signed(t)}};
            4'h9: alu_r = n >> t;
            4'hA: alu_r = t - DATA_W'(1);
            4'hB: alu_r = r;
            4'hC: alu_r = uart ? DATA_W'(cpu_uart_dat_i) : t;
            4'hD: alu_r = n << t;
            4'hE: alu_r = DATA_W'({rcount, dcount});
            default: alu_r = {DATA_W{n < t}};
        endcase
    end

    always_comb begin
        t_nx  = t;
        pc_nx = pc_inc;
        if (is_lit) begin
            t_nx = DATA_W'(insn[30:0]);
        end else if (is_jmp || is_call) begin
            pc_nx = target;
        end else if (is_cjmp) begin
            t_nx = n;
            if (t == '0) pc_nx = target;
        end else begin
            t_nx = alu_r;
            if (r2pc) pc_nx = r[PC_W+1:2];
        end
    end

    assign dwe = commit && (is_lit || (is_alu && t2n));
    assign rwe = commit && (is_call || (is_alu && t2r));
    assign rwd = is_call ? DATA_W'({pc_inc, 2'b00}) : t;

    always_ff @(posedge clk) begin
        if (dwe) dstack[dsp_nx] <= t;
        if (rwe) rstack[rsp_nx] <= rwd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= '0;
            insn      <= '0;
            t         <= '0;
            dsp       <= '0;
            rsp       <= '0;
            dcount    <= '0;
            rcount    <= '0;
            cpu_fault <= 1'b0;
            mem_adr   <= '0;
            mem_dat   <= '0;
            mem_we    <= 1'b0;
            mem_ld    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (cpu_start) begin
                    pc        <= cpu_start_adr;
                    dsp       <= '0;
                    rsp       <= '0;
                    dcount    <= '0;
                    rcount    <= '0;
                    cpu_fault <= 1'b0;
                    state     <= S_FETCH;
                end
                S_FETCH: if (inst_ack_i) begin
                    insn  <= inst_i;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (halt) begin
                        state <= S_HALT;
                    end else if (stk_fault) begin
                        cpu_fault <= 1'b1;
                        state     <= S_FAULT;
                    end else begin
                        pc     <= pc_nx;
                        t      <= t_nx;
                        dsp    <= dsp_nx;
                        rsp    <= rsp_nx;
                        dcount <= dcount_nx;
                        rcount <= rcount_nx;
                        if ((is_ld || is_st) && !uart) begin
                            mem_adr <= t;
                            mem_dat <= n;
                            mem_we  <= is_st;
                            mem_ld  <= is_ld;
                            state   <= S_MEM;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_MEM: if (ack_i) begin
                    if (mem_ld) t <= dat_i;
                    state <= S_FETCH;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign cpu_num        = 4'(CPU_NUM);
    assign busy           = state != S_IDLE;
    assign cpu_end        = state == S_EXEC && halt;
    assign inst_cyc_o     = state == S_FETCH;
    assign inst_pc_o      = pc;
    assign cyc_o          = state == S_MEM;
    assign we_o           = cyc_o && mem_we;
    assign adr_o          = mem_adr;
    assign dat_o          = mem_dat;
    assign cpu_uart_rd_o  = commit && is_ld && uart;
    assign cpu_uart_wr_o  = commit && is_st && uart;
    assign cpu_uart_adr_o = (cpu_uart_rd_o || cpu_uart_wr_o) && t[0];
    assign cpu_uart_dat_o = cpu_uart_wr_o ? n[7:0] : 8'h00;
endmodule

// File: tb/tb_j1_stack_core.sv
// Scoreboard bench for j1_stack_core: directed programs push expected fetches, bus cycles and UART
// strobes into queues; monitor processes act as memories and pop/compare whenever the core presents a request.
module tb_j1_stack_core;
    localparam int PC_W = 13;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cpu_start = 1'b0;
    logic [PC_W-1:0] cpu_start_adr = '0;
    logic            cpu_end, cpu_fault, busy;
    logic [3:0]      cpu_num;
    logic            inst_cyc_o;
    logic [PC_W-1:0] inst_pc_o;
    logic [31:0]     inst_i = '0;
    logic            inst_ack_i = 1'b0;
    logic            cyc_o, we_o;
    logic [31:0]     adr_o, dat_o;
    logic [31:0]     dat_i = '0;
    logic            ack_i = 1'b0;
    logic            cpu_uart_rd_o, cpu_uart_wr_o, cpu_uart_adr_o;
    logic [7:0]      cpu_uart_dat_o;
    logic [7:0]      cpu_uart_dat_i = 8'hA5;

    j1_stack_core dut (
        .clk(clk), .rst(rst), .cpu_start(cpu_start), .cpu_start_adr(cpu_start_adr),
        .cpu_end(cpu_end), .cpu_fault(cpu_fault), .busy(busy), .cpu_num(cpu_num),
        .inst_cyc_o(inst_cyc_o), .inst_pc_o(inst_pc_o), .inst_i(inst_i), .inst_ack_i(inst_ack_i),
        .cyc_o(cyc_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i),
        .cpu_uart_rd_o(cpu_uart_rd_o), .cpu_uart_wr_o(cpu_uart_wr_o),
        .cpu_uart_adr_o(cpu_uart_adr_o), .cpu_uart_dat_o(cpu_uart_dat_o),
        .cpu_uart_dat_i(cpu_uart_dat_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
    } dexp_t;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] imem [int];
    logic [31:0] dmem [int];
    int          fq[$];
    dexp_t       dq[$];
    logic [10:0] uq[$];
    dexp_t       cur;
    int          data_delay = 1;
    int          dcnt = 0;
    bit          in_txn = 0;
    int          end_cnt = 0;
    int          rd_cnt = 0;
    bit          end_d1 = 0, end_d2 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: unexpected request %0h, expected none", name, act);
    endtask

    // Instruction memory: same-cycle ack, address checked against the expected fetch stream.
    always @(negedge clk) begin
        inst_ack_i = 1'b0;
        if (inst_cyc_o) begin
            if (fq.size() == 0) unexpected("fetch", 64'(inst_pc_o));
            else check("fetch_pc", 64'(inst_pc_o), 64'(fq.pop_front()));
            inst_i = imem.exists(int'(inst_pc_o)) ? imem[int'(inst_pc_o)] : 32'h0;
            inst_ack_i = 1'b1;
        end
    end

    // Data memory: ack after data_delay cycles; every held cycle is compared, so drift shows up.
    always @(negedge clk) begin
        ack_i = 1'b0;
        if (cyc_o) begin
            if (!in_txn) begin
                in_txn = 1;
                dcnt = 0;
                if (dq.size() == 0) begin
                    unexpected("data_cyc", 64'(adr_o));
                    cur = '{adr_o, dat_o, we_o};
                end else begin
                    cur = dq.pop_front();
                end
            end
            dcnt++;
            check("data_adr", 64'(adr_o), 64'(cur.adr));
            check("data_we", 64'(we_o), 64'(cur.we));
            if (cur.we) check("data_dat", 64'(dat_o), 64'(cur.dat));
            dat_i = dmem.exists(int'(adr_o)) ? dmem[int'(adr_o)] : 32'h0;
            if (dcnt >= data_delay) begin
                ack_i = 1'b1;
                in_txn = 0;
                if (we_o) dmem[int'(adr_o)] = dat_o;
            end
        end else begin
            in_txn = 0;
        end
    end

    always @(negedge clk) begin
        if (cpu_uart_rd_o || cpu_uart_wr_o) begin
            if (cpu_uart_rd_o) rd_cnt++;
            if (uq.size() == 0) unexpected("uart", 64'({cpu_uart_rd_o, cpu_uart_wr_o, cpu_uart_adr_o, cpu_uart_dat_o}));
            else check("uart", 64'({cpu_uart_rd_o, cpu_uart_wr_o, cpu_uart_adr_o, cpu_uart_dat_o}), 64'(uq.pop_front()));
        end
    end

    // cpu_end counts cycles high; HALT takes one cycle, so busy must be low two cycles after the pulse.
    always @(negedge clk) begin
        if (end_d2) check("busy_after_end", 64'(busy), 64'd0);
        end_d2 = end_d1;
        end_d1 = cpu_end;
        if (cpu_end) end_cnt++;
    end

    task automatic run(input logic [PC_W-1:0] adr, input int budget, input string name);
        int i;
        end_cnt = 0;
        rd_cnt = 0;
        @(negedge clk);
        cpu_start_adr = adr;
        cpu_start = 1'b1;
        @(negedge clk);
        cpu_start = 1'b0;
        check({name, "_fault_clear"}, 64'(cpu_fault), 64'd0);
        check({name, "_busy"}, 64'(busy), 64'd1);
        i = 0;
        while (busy && i < budget) begin
            @(negedge clk);
            i++;
        end
        check({name, "_finished"}, 64'(busy), 64'd0);
        check({name, "_fetch_left"}, 64'(fq.size()), 64'd0);
        check({name, "_data_left"}, 64'(dq.size()), 64'd0);
        check({name, "_uart_left"}, 64'(uq.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_end", 64'(cpu_end), 64'd0);
        check("rst_fault", 64'(cpu_fault), 64'd0);
        check("rst_inst_cyc", 64'(inst_cyc_o), 64'd0);
        check("rst_cyc", 64'(cyc_o), 64'd0);
        check("rst_we", 64'(we_o), 64'd0);
        check("rst_adr", 64'(adr_o), 64'd0);
        check("rst_dat", 64'(dat_o), 64'd0);
        check("rst_uart", 64'({cpu_uart_rd_o, cpu_uart_wr_o, cpu_uart_adr_o, cpu_uart_dat_o}), 64'd0);
        check("cpu_num", 64'(cpu_num), 64'd1);
        rst = 1'b0;

        // lit 3; lit 4; +; ret
        imem[16'h10] = 32'h8000_0003; imem[16'h11] = 32'h8000_0004;
        imem[16'h12] = 32'h6200_0003; imem[16'h13] = 32'h7000_000C;
        for (int a = 16'h10; a <= 16'h13; a++) fq.push_back(a);
        run(13'h10, 50, "add");
        check("add_t", 64'(dut.t), 64'd7);
        check("add_dcount", 64'(dut.dcount), 64'd1);
        check("add_end_cycles", 64'(end_cnt), 64'd1);

        // lit 0x55; lit 0x100; !; lit 0x100; @; ret with 3-cycle ack delay
        data_delay = 3;
        imem[16'h20] = 32'h8000_0055; imem[16'h21] = 32'h8000_0100;
        imem[16'h22] = 32'h6100_0022; imem[16'h23] = 32'h8000_0100;
        imem[16'h24] = 32'h6C00_0000; imem[16'h25] = 32'h7000_000C;
        for (int a = 16'h20; a <= 16'h25; a++) fq.push_back(a);
        dq.push_back('{32'h100, 32'h55, 1'b1});
        dq.push_back('{32'h100, 32'h0, 1'b0});
        run(13'h20, 80, "mem");
        check("mem_t", 64'(dut.t), 64'h55);
        check("mem_dcount", 64'(dut.dcount), 64'd1);
        check("mem_end_cycles", 64'(end_cnt), 64'd1);
        data_delay = 1;

        // lit 0x0FFFFFFE; ~; @ (UART window); ret
        imem[16'h30] = 32'h8FFF_FFFE; imem[16'h31] = 32'h6600_0000;
        imem[16'h32] = 32'h6C00_0000; imem[16'h33] = 32'h7000_000C;
        for (int a = 16'h30; a <= 16'h33; a++) fq.push_back(a);
        uq.push_back(11'b1_0_1_0000_0000);
        run(13'h30, 50, "uart");
        check("uart_t", 64'(dut.t), 64'hA5);
        check("uart_rd_cycles", 64'(rd_cnt), 64'd1);

        // 33 literals: the 33rd push overflows a 32-deep data stack
        for (int k = 0; k < 33; k++) begin
            imem[16'h40 + k] = 32'h8000_0001 + k;
            fq.push_back(16'h40 + k);
        end
        run(13'h40, 200, "ovf");
        check("ovf_fault", 64'(cpu_fault), 64'd1);
        check("ovf_t", 64'(dut.t), 64'd32);
        check("ovf_dcount", 64'(dut.dcount), 64'd32);
        check("ovf_end", 64'(end_cnt), 64'd0);

        // + as first instruction underflows; the start also clears the earlier fault
        imem[16'h70] = 32'h6200_0003;
        fq.push_back(16'h70);
        run(13'h70, 20, "unf");
        check("unf_fault", 64'(cpu_fault), 64'd1);
        check("unf_dcount", 64'(dut.dcount), 64'd0);
        check("unf_end", 64'(end_cnt), 64'd0);

        // 1FFF: lit 0 -> 0000: call 1FFE -> 1FFE: 0branch 5 -> 0005: r> -> 0006: ret
        imem[16'h1FFF] = 32'h8000_0000; imem[16'h0000] = 32'h4000_1FFE;
        imem[16'h1FFE] = 32'h2000_0005; imem[16'h0005] = 32'h6B00_000D;
        imem[16'h0006] = 32'h7000_000C;
        fq.push_back(16'h1FFF); fq.push_back(0); fq.push_back(16'h1FFE);
        fq.push_back(5); fq.push_back(6);
        run(13'h1FFF, 50, "call");
        check("call_r", 64'(dut.t), 64'h4);
        check("call_dcount", 64'(dut.dcount), 64'd1);
        check("call_rcount", 64'(dut.rcount), 64'd0);
        check("call_end_cycles", 64'(end_cnt), 64'd1);

        // Async reset during a stalled MEM read
        data_delay = 1000;
        imem[16'h80] = 32'h8000_0100; imem[16'h81] = 32'h6C00_0000;
        fq.push_back(16'h80); fq.push_back(16'h81);
        dq.push_back('{32'h100, 32'h0, 1'b0});
        @(negedge clk);
        cpu_start_adr = 13'h80;
        cpu_start = 1'b1;
        @(negedge clk);
        cpu_start = 1'b0;
        i = 0;
        while (!cyc_o && i < 20) begin
            @(negedge clk);
            i++;
        end
        check("rstmem_cyc_seen", 64'(cyc_o), 64'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rstmem_cyc_drop", 64'(cyc_o), 64'd0);
        check("rstmem_idle", 64'(busy), 64'd0);
        check("rstmem_inst_cyc", 64'(inst_cyc_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        data_delay = 1;
        repeat (2) @(negedge clk);
        check("rstmem_still_idle", 64'(busy), 64'd0);
        check("rstmem_data_left", 64'(dq.size()), 64'd0);
        check("rstmem_fetch_left", 64'(fq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
